// File: rtl/mips_alu_hilo_pkg.sv
// Shared types for the HI/LO unit: ALU function codes and the divide FSM states.
package mips_alu_hilo_pkg;

  localparam int unsigned FUNC_W = 5;

  typedef enum logic [FUNC_W-1:0] {
    FUNC_ADD  = 5'd0,
    FUNC_ADDU = 5'd1,
    FUNC_SUB  = 5'd2,
    FUNC_SUBU = 5'd3,
    FUNC_AND  = 5'd4,
    FUNC_OR   = 5'd5,
    FUNC_XOR  = 5'd6,
    FUNC_NOR  = 5'd7,
    FUNC_SLT  = 5'd8,
    FUNC_SLTU = 5'd9,
    FUNC_SLL  = 5'd10,
    FUNC_SRL  = 5'd11,
    FUNC_SRA  = 5'd12,
    FUNC_LUI  = 5'd13,
    FUNC_MULS = 5'd14,
    FUNC_MULU = 5'd15,
    FUNC_DIVS = 5'd16,
    FUNC_DIVU = 5'd17,
    FUNC_MFHI = 5'd18,
    FUNC_MFLO = 5'd19,
    FUNC_MTHI = 5'd20,
    FUNC_MTLO = 5'd21
  } func_e;

  localparam int unsigned FUNC_LAST = 21;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_FIX  = 2'd2
  } hilo_state_e;

endpackage

// File: rtl/mips_alu_hilo_div.sv
// Iterative restoring divider core: magnitude capture, one quotient bit per step,
// and sign fix-up of the final quotient/remainder.
module mips_alu_div #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              step,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done_c,
  output logic [DATA_W-1:0] quotient_c,
  output logic [DATA_W-1:0] remainder_c
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] quo_q, rem_q, dvs_q;
  logic              neg_quo_q, neg_rem_q, divz_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              dvd_neg_c, dvs_neg_c;
  logic [DATA_W-1:0] dvd_mag_c, dvs_mag_c;
  logic [DATA_W:0]   partial_c, diff_c;

  always_comb begin
    dvd_neg_c = is_signed & dividend[DATA_W-1];
    dvs_neg_c = is_signed & divisor[DATA_W-1];
    dvd_mag_c = dvd_neg_c ? DATA_W'(-dividend) : dividend;
    dvs_mag_c = dvs_neg_c ? DATA_W'(-divisor) : divisor;
  end

  // Partial remainder is always below twice the divisor, so the (DATA_W+1)-bit
  // difference's MSB is a valid borrow flag. Divisor zero is overridden below.
  assign partial_c = {rem_q, quo_q[DATA_W-1]};
  assign diff_c    = partial_c - {1'b0, dvs_q};
  assign done_c    = step && (cnt_q == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
      cnt_q     <= '0;
    end else if (abort) begin
      cnt_q <= '0;
    end else if (start) begin
      quo_q     <= dvd_mag_c;
      rem_q     <= '0;
      dvs_q     <= dvs_mag_c;
      neg_quo_q <= dvd_neg_c ^ dvs_neg_c;
      neg_rem_q <= dvd_neg_c;
      divz_q    <= (divisor == '0);
      cnt_q     <= '0;
    end else if (step) begin
      rem_q <= diff_c[DATA_W] ? partial_c[DATA_W-1:0] : diff_c[DATA_W-1:0];
      quo_q <= {quo_q[DATA_W-2:0], ~diff_c[DATA_W]};
      cnt_q <= CNT_W'(cnt_q + 1'b1);
    end
  end

  // Remainder follows the dividend sign; with a zero divisor that reproduces data1.
  always_comb begin
    quotient_c  = neg_quo_q ? DATA_W'(-quo_q) : quo_q;
    remainder_c = neg_rem_q ? DATA_W'(-rem_q) : rem_q;
    if (divz_q) quotient_c = '1;
  end

endmodule

// File: rtl/mips_alu_hilo.sv
// HI/LO register unit: commits multiply/move-to results and runs multi-cycle divides,
// stalling the pipeline via busy while the divider is active.
module mips_alu_hilo
  import mips_alu_hilo_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              flush,
  input  logic [FUNC_W-1:0] func,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] alu_lo,
  input  logic [DATA_W-1:0] alu_hi,
  output logic [DATA_W-1:0] reg_lo,
  output logic [DATA_W-1:0] reg_hi,
  output logic              busy
);

  hilo_state_e       state_q, state_nxt;
  logic [DATA_W-1:0] hi_nxt, lo_nxt;
  func_e             fn_c;
  logic              accept_c, div_start_c, div_step_c, div_abort_c, div_done_c;
  logic [DATA_W-1:0] quotient_c, remainder_c;

  assign fn_c        = func_e'(func);
  assign accept_c    = (state_q == ST_IDLE) && valid_in && !flush;
  assign div_step_c  = (state_q == ST_DIV) && !flush;
  assign div_abort_c = (state_q != ST_IDLE) && flush;

  mips_alu_div #(.DATA_W(DATA_W)) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (div_start_c),
    .abort       (div_abort_c),
    .step        (div_step_c),
    .is_signed   (fn_c == FUNC_DIVS),
    .dividend    (data1),
    .divisor     (data2),
    .done_c      (div_done_c),
    .quotient_c  (quotient_c),
    .remainder_c (remainder_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      reg_hi  <= '0;
      reg_lo  <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      reg_hi  <= hi_nxt;
      reg_lo  <= lo_nxt;
      busy    <= (state_nxt != ST_IDLE);
    end
  end

  // Next state and HI/LO write select.
  always_comb begin
    state_nxt   = state_q;
    hi_nxt      = reg_hi;
    lo_nxt      = reg_lo;
    div_start_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          case (fn_c)
            FUNC_MULS, FUNC_MULU: begin
              hi_nxt = alu_hi;
              lo_nxt = alu_lo;
            end
            FUNC_MTLO: lo_nxt = alu_lo;
            FUNC_MTHI: hi_nxt = alu_hi;
            FUNC_DIVS, FUNC_DIVU: begin
              div_start_c = 1'b1;
              state_nxt   = ST_DIV;
            end
            default: ;
          endcase
        end
      end
      ST_DIV: begin
        if (flush)           state_nxt = ST_IDLE;
        else if (div_done_c) state_nxt = ST_FIX;
      end
      ST_FIX: begin
        state_nxt = ST_IDLE;
        if (!flush) begin
          lo_nxt = quotient_c;
          hi_nxt = remainder_c;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_alu_hilo.sv
// Self-checking bench for mips_alu_hilo: directed cases plus randomized traffic
// compared every cycle against a cycle-count behavioural model.
module tb_mips_alu_hilo;
  import mips_alu_hilo_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned DIV_CYC = DW + 1;

  logic          clk = 1'b0;
  logic          rst_n, valid_in, flush;
  logic [FUNC_W-1:0] func;
  logic [DW-1:0] data1, data2, alu_lo, alu_hi;
  logic [DW-1:0] reg_lo, reg_hi;
  logic          busy;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  mips_alu_hilo #(.DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .flush(flush), .func(func),
    .data1(data1), .data2(data2), .alu_lo(alu_lo), .alu_hi(alu_hi),
    .reg_lo(reg_lo), .reg_hi(reg_hi), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural divide result from plain arithmetic.
  function automatic void model_div(input logic sgn, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                    output logic [DW-1:0] q, output logic [DW-1:0] r);
    logic signed [DW-1:0] sa, sb;
    sa = a;
    sb = b;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = '0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  // Model: HI/LO values plus cycles left until a pending divide commits.
  logic [DW-1:0] m_hi, m_lo, p_hi, p_lo;
  int m_left;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_hi = '0; m_lo = '0; m_left = 0;
    end else if (m_left != 0) begin
      if (flush) m_left = 0;
      else begin
        m_left--;
        if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; end
      end
    end else if (valid_in && !flush) begin
      case (func_e'(func))
        FUNC_MULS, FUNC_MULU: begin m_hi = alu_hi; m_lo = alu_lo; end
        FUNC_MTLO: m_lo = alu_lo;
        FUNC_MTHI: m_hi = alu_hi;
        FUNC_DIVS, FUNC_DIVU: begin
          model_div(func_e'(func) == FUNC_DIVS, data1, data2, p_lo, p_hi);
          m_left = DIV_CYC;
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_hi", reg_hi, m_hi);
      check("cyc_lo", reg_lo, m_lo);
      check("cyc_busy", DW'(busy), DW'(m_left != 0));
    end
  end

  task automatic idle_inputs();
    valid_in = 1'b0; flush = 1'b0; func = FUNC_W'(FUNC_ADD);
    data1 = '0; data2 = '0; alu_hi = '0; alu_lo = '0;
  endtask

  task automatic issue(input func_e f, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                       input logic [DW-1:0] ahi, input logic [DW-1:0] alo);
    valid_in = 1'b1; func = FUNC_W'(f);
    data1 = d1; data2 = d2; alu_hi = ahi; alu_lo = alo;
    @(negedge clk);
    idle_inputs();
  endtask

  // Counts busy cycles until idle; optionally pulses an Mthi mid-divide.
  task automatic wait_idle(input bit poke, output int n);
    n = 0;
    for (int i = 0; i < 80; i++) begin
      if (!busy) break;
      n++;
      if (poke && i == 5) begin
        valid_in = 1'b1; func = FUNC_W'(FUNC_MTHI); alu_hi = 32'hDEAD_BEEF;
      end else idle_inputs();
      @(negedge clk);
    end
    if (busy) begin
      n_chk++; n_fail++;
      $display("FAIL wait_idle: busy still %b after 80 cycles", busy);
    end
  endtask

  initial begin
    int n;
    logic [DW-1:0] q, r;

    // Model pins
    model_div(1'b0, 32'd100, 32'd7, q, r);
    check("pin_divu_q", q, 32'd14);
    check("pin_divu_r", r, 32'd2);
    model_div(1'b1, 32'hFFFF_FFF9, 32'd2, q, r);
    check("pin_divs_q", q, 32'hFFFF_FFFD);
    check("pin_divs_r", r, 32'hFFFF_FFFF);

    // Reset with garbage inputs
    rst_n = 1'b0; valid_in = 1'b1; flush = 1'b0; func = FUNC_W'(FUNC_MULU);
    data1 = $urandom; data2 = $urandom; alu_hi = $urandom; alu_lo = $urandom;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; idle_inputs();
    check("rst_hi", reg_hi, '0);
    check("rst_lo", reg_lo, '0);
    check("rst_busy", DW'(busy), '0);

    // Multiply then move-to
    issue(FUNC_MULU, '0, '0, 32'h1, 32'hFFFF_FFFE);
    check("mulu_hi", reg_hi, 32'h1);
    check("mulu_lo", reg_lo, 32'hFFFF_FFFE);
    issue(FUNC_MTLO, '0, '0, 32'h77, 32'h5);
    check("mtlo_hi", reg_hi, 32'h1);
    check("mtlo_lo", reg_lo, 32'h5);

    // Divu 100/7 with an ignored Mthi during busy
    issue(FUNC_DIVU, 32'd100, 32'd7, '0, '0);
    wait_idle(1'b1, n);
    check("divu_busy_len", DW'(n), DW'(33));
    check("divu_lo", reg_lo, 32'd14);
    check("divu_hi", reg_hi, 32'd2);

    issue(FUNC_DIVS, 32'hFFFF_FFF9, 32'd2, '0, '0);
    wait_idle(1'b0, n);
    check("divs_lo", reg_lo, 32'hFFFF_FFFD);
    check("divs_hi", reg_hi, 32'hFFFF_FFFF);

    issue(FUNC_DIVS, 32'h8000_0000, 32'hFFFF_FFFF, '0, '0);
    wait_idle(1'b0, n);
    check("ovf_lo", reg_lo, 32'h8000_0000);
    check("ovf_hi", reg_hi, 32'h0);

    issue(FUNC_DIVU, 32'd5, 32'd0, '0, '0);
    wait_idle(1'b0, n);
    check("dz_busy_len", DW'(n), DW'(33));
    check("dz_lo", reg_lo, 32'hFFFF_FFFF);
    check("dz_hi", reg_hi, 32'd5);

    issue(FUNC_DIVS, 32'hFFFF_FFF6, 32'd0, '0, '0);
    wait_idle(1'b0, n);
    check("dzs_lo", reg_lo, 32'hFFFF_FFFF);
    check("dzs_hi", reg_hi, 32'hFFFF_FFF6);

    // Flush in cycle 10 of a divide
    issue(FUNC_MTHI, '0, '0, 32'hA, '0);
    issue(FUNC_MTLO, '0, '0, '0, 32'hB);
    issue(FUNC_DIVU, 32'd9, 32'd3, '0, '0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", DW'(busy), '0);
    repeat (3) @(negedge clk);
    check("flush_hi", reg_hi, 32'hA);
    check("flush_lo", reg_lo, 32'hB);

    // Reset in cycle 10 of a divide
    issue(FUNC_DIVU, 32'd9, 32'd3, '0, '0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rstdiv_busy", DW'(busy), '0);
    check("rstdiv_hi", reg_hi, '0);
    check("rstdiv_lo", reg_lo, '0);

    // Flush and valid together in IDLE
    flush = 1'b1;
    issue(FUNC_MULS, '0, '0, 32'h1234, 32'h5678);
    check("flushacc_hi", reg_hi, '0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int sel;
      rst_n    = ($urandom_range(0, 399) != 0);
      valid_in = $urandom_range(0, 1) == 1;
      flush    = ($urandom_range(0, 15) == 0);
      sel      = int'($urandom_range(0, 5));
      if (sel == 0)      func = FUNC_W'(FUNC_DIVS);
      else if (sel == 1) func = FUNC_W'(FUNC_DIVU);
      else               func = FUNC_W'($urandom_range(0, FUNC_LAST));
      data1  = $urandom;
      data2  = $urandom;
      alu_hi = $urandom;
      alu_lo = $urandom;
      case ($urandom_range(0, 7))
        0: data2 = '0;
        1: begin data1 = 32'h8000_0000; data2 = 32'hFFFF_FFFF; end
        2: data2 = DW'($urandom_range(1, 20));
        3: data2 = -DW'($urandom_range(1, 20));
        default: ;
      endcase
      @(negedge clk);
    end
    rst_n = 1'b1;
    idle_inputs();
    repeat (40) @(negedge clk);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
